// File: rtl/wt_wbuf_pkg.sv
// Shared types for the write-through store buffer: entry record, entry state and word-address helper.
// Entry fields are sized for the widest supported configuration (64-bit address and data).
package wt_wbuf_pkg;

  localparam int unsigned WBUF_MAX_ADDR_W = 64;
  localparam int unsigned WBUF_MAX_DATA_W = 64;
  localparam int unsigned WBUF_MAX_BE_W   = WBUF_MAX_DATA_W / 8;

  typedef struct packed {
    logic [WBUF_MAX_ADDR_W-1:0] addr;
    logic [WBUF_MAX_DATA_W-1:0] data;
    logic [WBUF_MAX_BE_W-1:0]   be;
    logic                       nc;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2
  } wbuf_state_e;

  function automatic logic [WBUF_MAX_ADDR_W-1:0] word_addr(
    input logic [WBUF_MAX_ADDR_W-1:0] addr,
    input int unsigned                lsb
  );
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/wt_wbuf_ptr_ctrl.sv
// Ring pointers (ack <= issue <= tail, each with a wrap bit) and the derived occupancy/in-flight/pending counts.
// Acks arriving with nothing in flight are dropped here.
module wt_wbuf_ptr_ctrl #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDX_W          = $clog2(DEPTH),
  localparam int unsigned PTR_W          = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_i,
  input  logic             issue_i,
  input  logic             ack_i,
  output logic [IDX_W-1:0] tail_idx_o,
  output logic [IDX_W-1:0] newest_idx_o,
  output logic [IDX_W-1:0] iss_idx_o,
  output logic [IDX_W-1:0] ack_idx_o,
  output logic [PTR_W-1:0] occupancy_o,
  output logic [PTR_W-1:0] inflight_o,
  output logic [PTR_W-1:0] pending_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             can_issue_o
);

  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] iss_q, iss_d;
  logic [PTR_W-1:0] ack_q, ack_d;
  logic             ack_taken;

  always_comb begin
    occupancy_o = tail_q - ack_q;
    inflight_o  = iss_q - ack_q;
    pending_o   = tail_q - iss_q;
    full_o      = (occupancy_o == PTR_W'(DEPTH));
    empty_o     = (occupancy_o == '0);
    can_issue_o = (pending_o != '0) && (inflight_o < PTR_W'(MAX_OUTSTANDING));
    ack_taken   = ack_i && (inflight_o != '0);
    tail_d      = tail_q + PTR_W'(alloc_i);
    iss_d       = iss_q + PTR_W'(issue_i);
    ack_d       = ack_q + PTR_W'(ack_taken);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tail_q <= '0;
      iss_q  <= '0;
      ack_q  <= '0;
    end else begin
      tail_q <= tail_d;
      iss_q  <= iss_d;
      ack_q  <= ack_d;
    end
  end

  assign tail_idx_o   = tail_q[IDX_W-1:0];
  assign newest_idx_o = tail_q[IDX_W-1:0] - IDX_W'(1);
  assign iss_idx_o    = iss_q[IDX_W-1:0];
  assign ack_idx_o    = ack_q[IDX_W-1:0];

endmodule

// File: rtl/wt_wbuf_coalesce.sv
// Write-through store buffer with same-word byte-merge coalescing, in-order issue limit and load-hazard detect.
// Define WT_WBUF_FWD_EN to add store-to-load forwarding (ld_be_i, ld_fwd_valid_o, ld_fwd_data_o).
module wt_wbuf_coalesce
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned BE_W           = DATA_WIDTH / 8,
  localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [ADDR_WIDTH-1:0] st_addr_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic [BE_W-1:0]       st_be_i,
  input  logic                  st_nc_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_data_o,
  output logic [BE_W-1:0]       mem_req_be_o,
  output logic                  mem_req_nc_o,
  input  logic                  mem_ack_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  output logic                  ld_hazard_o,
  output logic                  empty_o,
  output logic [OUT_W-1:0]      outstanding_o
`ifdef WT_WBUF_FWD_EN
  ,
  input  logic [BE_W-1:0]       ld_be_i,
  output logic                  ld_fwd_valid_o,
  output logic [DATA_WIDTH-1:0] ld_fwd_data_o
`endif
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned OFFS_W = $clog2(BE_W);

  logic [IDX_W-1:0] tail_idx, newest_idx, iss_idx, ack_idx, wr_idx;
  logic [PTR_W-1:0] occupancy, inflight, pending;
  logic             full, can_issue, issue_fire, coalesce, accept, alloc;
  logic [WBUF_MAX_ADDR_W-1:0] st_word, ld_word;
  wbuf_entry_t      entry_q [DEPTH];
  wbuf_entry_t      newest, wr_entry;
  wbuf_state_e [DEPTH-1:0] state;
  logic [DEPTH-1:0] ld_hit;

  wt_wbuf_ptr_ctrl #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ptr_ctrl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_i      (alloc),
    .issue_i      (issue_fire),
    .ack_i        (mem_ack_i),
    .tail_idx_o   (tail_idx),
    .newest_idx_o (newest_idx),
    .iss_idx_o    (iss_idx),
    .ack_idx_o    (ack_idx),
    .occupancy_o  (occupancy),
    .inflight_o   (inflight),
    .pending_o    (pending),
    .full_o       (full),
    .empty_o      (empty_o),
    .can_issue_o  (can_issue)
  );

  assign mem_req_valid_o = can_issue;
  assign issue_fire      = can_issue && mem_req_ready_i;

  // Merging into an entry that leaves on this same edge would lose the new bytes.
  always_comb begin
    newest   = entry_q[newest_idx];
    st_word  = word_addr(WBUF_MAX_ADDR_W'(st_addr_i), OFFS_W);
    coalesce = (pending != '0) &&
               (word_addr(newest.addr, OFFS_W) == st_word) &&
               !newest.nc && !st_nc_i &&
               !(issue_fire && (pending == PTR_W'(1)));
    st_ready_o = coalesce || !full;
    accept     = st_valid_i && st_ready_o;
    alloc      = accept && !coalesce;
    wr_idx     = coalesce ? newest_idx : tail_idx;
    if (coalesce) begin
      wr_entry = newest;
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (st_be_i[b]) wr_entry.data[8*b +: 8] = st_data_i[8*b +: 8];
      end
      wr_entry.be[BE_W-1:0] = newest.be[BE_W-1:0] | st_be_i;
    end else begin
      wr_entry                       = '0;
      wr_entry.addr[ADDR_WIDTH-1:0]  = st_addr_i;
      wr_entry.data[DATA_WIDTH-1:0]  = st_data_i;
      wr_entry.be[BE_W-1:0]          = st_be_i;
      wr_entry.nc                    = st_nc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else if (accept) begin
      entry_q[wr_idx] <= wr_entry;
    end
  end

  assign mem_req_addr_o = {entry_q[iss_idx].addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
  assign mem_req_data_o = entry_q[iss_idx].data[DATA_WIDTH-1:0];
  assign mem_req_be_o   = entry_q[iss_idx].be[BE_W-1:0];
  assign mem_req_nc_o   = entry_q[iss_idx].nc;
  assign outstanding_o  = inflight[OUT_W-1:0];

  assign ld_word = word_addr(WBUF_MAX_ADDR_W'(ld_addr_i), OFFS_W);

  // Entry state follows from its distance past ack_ptr.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_state
    logic [IDX_W-1:0] rel;
    logic [PTR_W-1:0] rel_ext;
    assign rel         = IDX_W'(gi) - ack_idx;
    assign rel_ext     = {1'b0, rel};
    assign state[gi]   = (rel_ext < inflight)  ? INFLIGHT :
                         (rel_ext < occupancy) ? PENDING  : FREE;
    assign ld_hit[gi]  = (state[gi] != FREE) &&
                         (word_addr(entry_q[gi].addr, OFFS_W) == ld_word);
  end

  assign ld_hazard_o = |ld_hit;

`ifdef WT_WBUF_FWD_EN
  logic             fwd_found;
  logic [IDX_W-1:0] fwd_idx, scan_idx;

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = ack_idx + IDX_W'(k);
      if (ld_hit[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
    ld_fwd_valid_o = fwd_found && ((entry_q[fwd_idx].be[BE_W-1:0] & ld_be_i) == ld_be_i);
    ld_fwd_data_o  = entry_q[fwd_idx].data[DATA_WIDTH-1:0];
  end
`endif

  stray_ack_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                !(mem_ack_i && (inflight == '0)))
    else $warning("mem_ack_i with no store in flight; ack ignored");

endmodule

// File: doc/wt_wbuf_coalesce.md
Name: wt_wbuf_coalesce

Overview:
- Parametrised write-through store buffer for the CVA6 FPGA softcore data path; it sits between the store unit and the WT dcache memory port.
- Generalises the fixed 2-entry write buffer: depth, address/data width and outstanding-store limit are all parameters.
- Adds byte-merge coalescing of same-word cacheable stores, an in-order outstanding-store limit and a load-hazard flag.

Parameters:
DEPTH, 4, entry count; power of two, >=2
ADDR_WIDTH, 32, store address width
DATA_WIDTH, 32, data word width (XLEN); BE width = DATA_WIDTH/8
MAX_OUTSTANDING, 4, max issued-but-unacked stores; 1..DEPTH

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
st_valid_i  in  1  store request valid
st_ready_o  out  1  store accepted when valid&ready
st_addr_i  in  ADDR_WIDTH  byte address; word-aligned internally
st_data_i  in  DATA_WIDTH  store data, lane-aligned
st_be_i  in  DATA_WIDTH/8  byte enables
st_nc_i  in  1  non-cacheable/non-idempotent; never coalesced
mem_req_valid_o  out  1  oldest pending entry offered to memory
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_WIDTH  word-aligned address (low bits 0)
mem_req_data_o  out  DATA_WIDTH  merged data
mem_req_be_o  out  DATA_WIDTH/8  merged byte enables
mem_req_nc_o  out  1  nc flag of entry
mem_ack_i  in  1  in-order completion of oldest in-flight store
ld_addr_i  in  ADDR_WIDTH  load address to check
ld_hazard_o  out  1  any non-free entry matches ld_addr_i word
empty_o  out  1  no pending or in-flight entries
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count

Behaviour:
- Ring of DEPTH entries; pointers ack_ptr <= iss_ptr <= tail_ptr (mod DEPTH, extra wrap bit).
  - [ack_ptr, iss_ptr): INFLIGHT. [iss_ptr, tail_ptr): PENDING. Rest: FREE.
- Reset state:
  - All pointers 0, all entries FREE.
  - st_ready_o=1, mem_req_valid_o=0, mem_req_* data outputs=0, ld_hazard_o=0, empty_o=1, outstanding_o=0.
- Coalesce condition, all of:
  - newest entry (tail_ptr-1) is PENDING;
  - word address equal;
  - both entries have nc=0;
  - that entry is not being issued this cycle (mem_req_valid_o & mem_req_ready_i & iss_ptr==tail_ptr-1).
  - On accept: entry data bytes with st_be_i set are overwritten, be |= st_be_i, no pointer move.
- Otherwise accept allocates at tail_ptr and advances tail_ptr.
- st_ready_o = coalesce_cond | (occupancy < DEPTH).
  - Combinational from registers and st_* inputs.
  - No same-cycle ack bypass: full stays not-ready even when mem_ack_i=1.
- Issue:
  - mem_req_valid_o = (iss_ptr != tail_ptr) & (inflight < MAX_OUTSTANDING).
  - Outputs come from the entry register at iss_ptr.
  - valid&ready advances iss_ptr; the entry becomes INFLIGHT.
  - Payload holds stable while valid&!ready.
- Latency: a store accepted in cycle N is visible on mem_req at N+1 at the earliest.
- mem_ack_i:
  - Frees the entry at ack_ptr and advances ack_ptr.
  - Ack with inflight==0 is ignored; the assertion fires.
  - Ack and issue in the same cycle: count unchanged, both pointers move.
- Simultaneous accept, issue and ack are all applied in one cycle.
- ld_hazard_o compares word addresses (low $clog2(DATA_WIDTH/8) bits ignored) against PENDING and INFLIGHT entries. Combinational.
- Reset mid-operation: pending and in-flight stores are discarded; later acks are ignored.

Optional Feature:
- Macro WT_WBUF_FWD_EN.
- Defined:
  - Extra outputs ld_fwd_valid_o (1) and ld_fwd_data_o (DATA_WIDTH).
  - The youngest matching entry forwards when its be covers every byte of ld_be_i (extra input).
  - ld_hazard_o stays asserted regardless.
- Undefined:
  - Those ports and ld_be_i are absent.
  - Only ld_hazard_o is produced.

Decomposition:
- Package wt_wbuf_pkg holds:
  - wbuf_entry_t {addr, data, be, nc};
  - wbuf_state_e {FREE, PENDING, INFLIGHT};
  - function word_addr().
- One sub-module: wt_wbuf_ptr_ctrl, the pointer/occupancy/inflight counter logic with wrap bits.
- Entry storage, merge and compare stay in the top.

Test Plan:
- Reset, then store 0x8000_0004 data 0x11223344 be 0xF -> next cycle mem_req_valid_o=1, addr 0x8000_0004, be 0xF; empty_o=0.
- mem_req_ready_i=0; stores 0x8000_0010 be 0x1 data 0xAA, then be 0x4 data 0x00CC0000 -> single entry, data 0x00CC00AA, be 0x5.
- Same two stores with st_nc_i=1 -> two entries issued in order, no merge.
- DEPTH=4, MAX_OUTSTANDING=2, ready=1, no ack, 4 stores to distinct words -> exactly 2 issued, outstanding_o=2, st_ready_o=0 on the 5th distinct store. One mem_ack_i -> 3rd issues next cycle.
- ld_addr_i=0x8000_0012 while the 0x8000_0010 entry is in flight -> ld_hazard_o=1. After its ack -> 0.
- rst_i asserted with 3 entries pending -> next cycle empty_o=1, mem_req_valid_o=0. A following mem_ack_i is ignored and outstanding_o stays 0.
